// File: rtl/ula_pkg.sv
// Shared encodings for the multicycle ALU: opcode classes, funct sub-ops,
// FSM state type and the helper that decides whether an op runs iteratively.
package ula_pkg;

  localparam logic [5:0] OP_ARIT  = 6'd0;
  localparam logic [5:0] OP_LOGIC = 6'd1;
  localparam logic [5:0] OP_ADDI  = 6'd2;
  localparam logic [5:0] OP_MOVE  = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_JUMP  = 6'd5;
  localparam logic [5:0] OP_LOAD  = 6'd6;
  localparam logic [5:0] OP_STORE = 6'd7;
  localparam logic [5:0] OP_IN    = 6'd8;
  localparam logic [5:0] OP_OUT   = 6'd9;
  localparam logic [5:0] OP_BEQ   = 6'd10;
  localparam logic [5:0] OP_BNE   = 6'd11;
  localparam logic [5:0] OP_SNE   = 6'd13;
  localparam logic [5:0] OP_SGT   = 6'd15;
  localparam logic [5:0] OP_SEQ   = 6'd16;
  localparam logic [5:0] OP_SGE   = 6'd17;
  localparam logic [5:0] OP_SLE   = 6'd18;
  localparam logic [5:0] OP_JR    = 6'd19;
  localparam logic [5:0] OP_SUBI  = 6'd20;
  localparam logic [5:0] OP_WRITE = 6'd30;
  localparam logic [5:0] OP_READ  = 6'd31;

  // funct values under OP_ARIT
  localparam logic [5:0] FN_ADD  = 6'd0;
  localparam logic [5:0] FN_SUB  = 6'd1;
  localparam logic [5:0] FN_MULT = 6'd2;
  localparam logic [5:0] FN_DIV  = 6'd3;
  localparam logic [5:0] FN_INC  = 6'd4;
  localparam logic [5:0] FN_DEC  = 6'd5;

  // funct values under OP_LOGIC
  localparam logic [5:0] FN_AND  = 6'd0;
  localparam logic [5:0] FN_OR   = 6'd1;
  localparam logic [5:0] FN_NOT  = 6'd2;
  localparam logic [5:0] FN_XOR  = 6'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // DIV is always iterative; MULT only when the combinational multiplier is off.
  function automatic logic is_iterative(input logic [5:0] op, input logic [5:0] fn,
                                        input logic fast_mul);
    return (op == OP_ARIT) && ((fn == FN_DIV) || ((fn == FN_MULT) && !fast_mul));
  endfunction

endpackage

// File: rtl/ula_muldiv_seq.sv
// WIDTH-step sequential core: shift-add multiply (mode 0) or restoring unsigned
// divide (mode 1). One step per cycle after the start cycle; done pulses after the last.
module ula_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod_hi,
  output logic [WIDTH-1:0] o_prod_lo,
  output logic [WIDTH-1:0] o_quot
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // r_hi/r_lo are the 2*WIDTH product accumulator, or remainder/quotient when dividing
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_add  = {1'b0, r_hi} + {1'b0, r_b};
  assign w_rem  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge   = (w_rem >= {1'b0, r_b});
  // When w_ge holds the true difference is below r_b, so the low bits are exact
  assign w_diff = w_rem[WIDTH-1:0] - r_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_mode <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_hi   <= '0;
        r_lo   <= i_a;
        r_b    <= i_b;
        r_mode <= i_mode;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_mode) begin
          r_hi <= w_ge ? w_diff : w_rem[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], w_ge};
        end else if (r_lo[0]) begin
          {r_hi, r_lo} <= {w_add, r_lo[WIDTH-1:1]};
        end else begin
          {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
        end
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_prod_hi = r_hi;
  assign o_prod_lo = r_lo;
  assign o_quot    = r_lo;

endmodule

// File: rtl/ula_multiciclo.sv
// Registered multicycle ALU: latches operands on start, runs single-cycle ops in
// EXEC or MULT/DIV through the sequential core, and pulses done with held results.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] Dados_1,
  input  logic [WIDTH-1:0] Dados_2,
  output logic [WIDTH-1:0] Resultado,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy,
  output logic             done,
  output state_t           o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: a request is taken on the edge where start=1 and busy=0. busy then
  // stays high up to and including the single done cycle, so a start in that cycle
  // is dropped and the earliest next accept is the cycle right after done.
  state_t           r_state;
  logic [5:0]       r_op;
  logic [5:0]       r_fn;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_div;
  logic [CW-1:0]    r_iter;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_iter_op;
  logic             w_md_busy;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_quot;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_res;
  logic             w_zero;
  logic             w_ovf;

  assign w_accept  = start && !r_busy;
  assign w_iter_op = is_iterative(Opcode, funct, FAST_MUL);
  assign w_prod    = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  ula_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .i_start   (w_accept && w_iter_op),
    .i_mode    (funct == FN_DIV),
    .i_a       (Dados_1),
    .i_b       (Dados_2),
    .o_busy    (w_md_busy),
    .o_done    (w_md_done),
    .o_prod_hi (w_md_hi),
    .o_prod_lo (w_md_lo),
    .o_quot    (w_md_quot)
  );

  // Single-cycle result from the latched operands
  always_comb begin
    w_res  = '0;
    w_zero = 1'b0;
    w_ovf  = 1'b0;
    case (r_op)
      OP_ARIT: begin
        case (r_fn)
          FN_ADD:  w_res = r_a + r_b;
          FN_SUB:  w_res = r_a - r_b;
          FN_MULT: begin
            if (FAST_MUL) begin
              w_res = w_prod[WIDTH-1:0];
              w_ovf = |w_prod[2*WIDTH-1:WIDTH];
            end
          end
          FN_INC:  w_res = r_a + WIDTH'(1);
          FN_DEC:  w_res = r_a - WIDTH'(1);
          default: w_res = '0;
        endcase
      end
      OP_LOGIC: begin
        case (r_fn)
          FN_AND:  w_res = r_a & r_b;
          FN_OR:   w_res = r_a | r_b;
          FN_NOT:  w_res = ~r_a;
          FN_XOR:  w_res = r_a ^ r_b;
          default: w_res = '0;
        endcase
      end
      OP_ADDI, OP_LOAD, OP_STORE, OP_IN, OP_WRITE, OP_READ: w_res = r_a + r_b;
      OP_SUBI:         w_res = r_a - r_b;
      OP_MOVE, OP_OUT: w_res = r_a;
      OP_SLT:  w_res = WIDTH'(r_a < r_b);
      OP_SNE:  w_res = WIDTH'(r_a != r_b);
      OP_SGT:  w_res = WIDTH'(r_a > r_b);
      OP_SEQ:  w_res = WIDTH'(r_a == r_b);
      OP_SGE:  w_res = WIDTH'(r_a >= r_b);
      OP_SLE:  w_res = WIDTH'(r_a <= r_b);
      OP_JUMP: begin
        w_res  = r_b;
        w_zero = 1'b1;
      end
      OP_BEQ:  w_zero = (r_a == r_b);
      OP_BNE:  w_zero = (r_a != r_b);
      OP_JR:   w_zero = 1'b1;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_fn    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_iter  <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_done) r_busy <= 1'b0;
          if (w_accept) begin
            r_op    <= Opcode;
            r_fn    <= funct;
            r_a     <= Dados_1;
            r_b     <= Dados_2;
            r_div   <= (funct == FN_DIV);
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= w_iter_op ? ST_ITER : ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res   <= w_res;
          r_zero  <= w_zero;
          r_ovf   <= w_ovf;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_ITER: begin
          r_iter <= r_iter + CW'(1);
          if ((r_iter == LAST) || !w_md_busy) r_state <= ST_FIN;
        end
        ST_FIN: begin
          // The core finished on the edge that entered FIN; its done is high now
          if (w_md_done) begin
            if (r_div) begin
              if (r_b == '0) begin
                r_res <= '1;
                r_ovf <= 1'b1;
              end else begin
                r_res <= w_md_quot;
                r_ovf <= 1'b0;
              end
            end else begin
              r_res <= w_md_lo;
              r_ovf <= |w_md_hi;
            end
            r_zero  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Resultado   = r_res;
  assign Zero        = r_zero;
  assign Overflow    = r_ovf;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: a WIDTH=32 iterative instance and a
// WIDTH=8 FAST_MUL instance, checked against an arithmetic reference model.
module tb_ula_multiciclo;
  import ula_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        s32, z32, o32, busy32, done32;
  logic [5:0]  op32, fn32;
  logic [31:0] a32, b32, res32;
  state_t      st32;

  logic        s8, z8, o8, busy8, done8;
  logic [5:0]  op8, fn8;
  logic [7:0]  a8, b8, res8;
  state_t      st8;

  ula_multiciclo #(.WIDTH(32), .FAST_MUL(1'b0)) u32 (
    .clock(clk), .reset(rst), .start(s32), .Opcode(op32), .funct(fn32),
    .Dados_1(a32), .Dados_2(b32), .Resultado(res32), .Zero(z32), .Overflow(o32),
    .busy(busy32), .done(done32), .o_dbg_state(st32)
  );

  ula_multiciclo #(.WIDTH(8), .FAST_MUL(1'b1)) u8 (
    .clock(clk), .reset(rst), .start(s8), .Opcode(op8), .funct(fn8),
    .Dados_1(a8), .Dados_2(b8), .Resultado(res8), .Zero(z8), .Overflow(o8),
    .busy(busy8), .done(done8), .o_dbg_state(st8)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ovf;
    int          lat;
    longint      acc;
  } exp_t;

  exp_t exp_q32[$];
  exp_t exp_q8[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Reference model: plain arithmetic on wide integers, masked to the width
  function automatic exp_t model(input int w, input bit fast, input logic [5:0] op,
                                 input logic [5:0] fn, input logic [63:0] a_in,
                                 input logic [63:0] b_in);
    exp_t e;
    logic [127:0] mask, a, b, r, p;
    mask   = (128'd1 << w) - 128'd1;
    a      = {64'd0, a_in} & mask;
    b      = {64'd0, b_in} & mask;
    r      = '0;
    p      = '0;
    e.zero = 1'b0;
    e.ovf  = 1'b0;
    e.acc  = 0;
    e.lat  = (op == 6'd0 && (fn == 6'd3 || (fn == 6'd2 && !fast))) ? w + 1 : 1;
    case (op)
      6'd0: begin
        case (fn)
          6'd0: r = a + b;
          6'd1: r = a - b;
          6'd2: begin p = a * b; r = p; e.ovf = ((p >> w) != '0); end
          6'd3: begin
            if (b == '0) begin r = mask; e.ovf = 1'b1; end
            else r = a / b;
          end
          6'd4: r = a + 128'd1;
          6'd5: r = a - 128'd1;
          default: r = '0;
        endcase
      end
      6'd1: begin
        case (fn)
          6'd0: r = a & b;
          6'd1: r = a | b;
          6'd2: r = ~a;
          6'd3: r = a ^ b;
          default: r = '0;
        endcase
      end
      6'd2, 6'd6, 6'd7, 6'd8, 6'd30, 6'd31: r = a + b;
      6'd20: r = a - b;
      6'd3, 6'd9: r = a;
      6'd4:  r = (a <  b) ? 128'd1 : 128'd0;
      6'd13: r = (a != b) ? 128'd1 : 128'd0;
      6'd15: r = (a >  b) ? 128'd1 : 128'd0;
      6'd16: r = (a == b) ? 128'd1 : 128'd0;
      6'd17: r = (a >= b) ? 128'd1 : 128'd0;
      6'd18: r = (a <= b) ? 128'd1 : 128'd0;
      6'd5:  begin r = b; e.zero = 1'b1; end
      6'd10: e.zero = (a == b);
      6'd11: e.zero = (a != b);
      6'd19: e.zero = 1'b1;
      default: r = '0;
    endcase
    e.res = r[63:0] & mask[63:0];
    return e;
  endfunction

  // ---------------- monitors ----------------
  exp_t mon_e32, mon_e8;

  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (exp_q32.size() == 0) begin
        n_checks++;
        $display("FAIL u32_unexpected_done: got done=1 required no pending op");
      end else begin
        mon_e32 = exp_q32.pop_front();
        chk("u32_res",     64'(res32), mon_e32.res);
        chk("u32_zero",    64'(z32),   64'(mon_e32.zero));
        chk("u32_ovf",     64'(o32),   64'(mon_e32.ovf));
        chk("u32_latency", 64'(cyc - mon_e32.acc), 64'(mon_e32.lat));
        chk("u32_busy_at_done", 64'(busy32), 64'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (exp_q8.size() == 0) begin
        n_checks++;
        $display("FAIL u8_unexpected_done: got done=1 required no pending op");
      end else begin
        mon_e8 = exp_q8.pop_front();
        chk("u8_res",     64'(res8), mon_e8.res);
        chk("u8_zero",    64'(z8),   64'(mon_e8.zero));
        chk("u8_ovf",     64'(o8),   64'(mon_e8.ovf));
        chk("u8_latency", 64'(cyc - mon_e8.acc), 64'(mon_e8.lat));
        chk("u8_busy_at_done", 64'(busy8), 64'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic busy_of(input bit is8);
    return is8 ? busy8 : busy32;
  endfunction

  task automatic drive(input bit is8, input logic st, input logic [5:0] op,
                       input logic [5:0] fn, input logic [63:0] a, input logic [63:0] b);
    if (is8) begin
      s8 = st; op8 = op; fn8 = fn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      s32 = st; op32 = op; fn32 = fn; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  task automatic push_exp(input bit is8, input logic [5:0] op, input logic [5:0] fn,
                          input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e = model(is8 ? 8 : 32, is8, op, fn, a, b);
    e.acc = cyc + 1;
    if (is8) exp_q8.push_back(e);
    else     exp_q32.push_back(e);
  endtask

  task automatic wait_idle(input bit is8);
    int guard;
    guard = 0;
    while (busy_of(is8) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      $display("FAIL wait_idle: got busy=1 required 0 within 200 cycles");
    end
  endtask

  task automatic issue(input bit is8, input logic [5:0] op, input logic [5:0] fn,
                       input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    wait_idle(is8);
    drive(is8, 1'b1, op, fn, a, b);
    push_exp(is8, op, fn, a, b);
    @(negedge clk);
    if (is8) s8 = 1'b0;
    else     s32 = 1'b0;
  endtask

  // start held high across a DIV while inputs churn; then a second op right after done
  task automatic held_start(input bit is8, input logic [63:0] a, input logic [63:0] b,
                            input logic [5:0] op2, input logic [5:0] fn2,
                            input logic [63:0] a2, input logic [63:0] b2);
    int guard;
    @(negedge clk);
    wait_idle(is8);
    drive(is8, 1'b1, 6'd0, 6'd3, a, b);
    push_exp(is8, 6'd0, 6'd3, a, b);
    guard = 0;
    do begin
      @(negedge clk);
      drive(is8, 1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)),
            {$urandom, $urandom}, {$urandom, $urandom});
      guard++;
    end while (busy_of(is8) && guard < 200);
    drive(is8, 1'b1, op2, fn2, a2, b2);
    push_exp(is8, op2, fn2, a2, b2);
    @(negedge clk);
    chk(is8 ? "u8_b2b_accept" : "u32_b2b_accept", 64'(busy_of(is8)), 64'd1);
    if (is8) s8 = 1'b0;
    else     s32 = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q32.size() != 0 || exp_q8.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      n_checks++;
      $display("FAIL drain: got %0d/%0d pending required 0/0", exp_q32.size(), exp_q8.size());
      exp_q32.delete();
      exp_q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_u32_res"},   64'(res32),  64'd0);
    chk({tag, "_u32_zero"},  64'(z32),    64'd0);
    chk({tag, "_u32_ovf"},   64'(o32),    64'd0);
    chk({tag, "_u32_busy"},  64'(busy32), 64'd0);
    chk({tag, "_u32_done"},  64'(done32), 64'd0);
    chk({tag, "_u32_state"}, 64'(st32),   64'(ST_IDLE));
    chk({tag, "_u8_res"},    64'(res8),   64'd0);
    chk({tag, "_u8_busy"},   64'(busy8),  64'd0);
    chk({tag, "_u8_state"},  64'(st8),    64'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  int         pulses;
  int         sel;
  logic [5:0] rop, rfn;
  logic [63:0] ra, rb;

  initial begin
    drive(1'b0, 1'b0, 6'd0, 6'd0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 6'd0, 6'd0, 64'd0, 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // directed, WIDTH=32 iterative
    issue(1'b0, 6'd0,  6'd0, 64'hFFFF_FFFF, 64'd1);
    issue(1'b0, 6'd0,  6'd2, 64'h1_0000, 64'h1_0000);
    issue(1'b0, 6'd0,  6'd2, 64'd7, 64'd6);
    issue(1'b0, 6'd0,  6'd3, 64'd100, 64'd7);
    issue(1'b0, 6'd0,  6'd3, 64'd5, 64'd0);
    issue(1'b0, 6'd10, 6'd0, 64'd9, 64'd9);
    issue(1'b0, 6'd11, 6'd0, 64'd9, 64'd9);
    issue(1'b0, 6'd5,  6'd0, 64'h123, 64'h40);
    issue(1'b0, 6'd19, 6'd0, 64'd1, 64'd2);
    issue(1'b0, 6'd20, 6'd0, 64'd3, 64'd5);
    issue(1'b0, 6'd1,  6'd2, 64'hF0F0, 64'd0);
    issue(1'b0, 6'd0,  6'd5, 64'd0, 64'd0);
    issue(1'b0, 6'd4,  6'd0, 64'd3, 64'd5);
    issue(1'b0, 6'd0,  6'd6, 64'd3, 64'd5);
    issue(1'b0, 6'd40, 6'd0, 64'd3, 64'd5);
    // directed, WIDTH=8 with fast multiply
    issue(1'b1, 6'd0,  6'd2, 64'd20, 64'd20);
    issue(1'b1, 6'd0,  6'd2, 64'd7, 64'd6);
    issue(1'b1, 6'd0,  6'd3, 64'd9, 64'd0);
    issue(1'b1, 6'd0,  6'd0, 64'hFF, 64'd1);
    issue(1'b1, 6'd0,  6'd1, 64'd0, 64'd1);
    drain();

    // reset in the middle of a divide
    issue(1'b0, 6'd0, 6'd3, 64'd100, 64'd7);
    drain();
    issue(1'b0, 6'd0, 6'd3, 64'hFFFF, 64'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    exp_q32.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("abort");
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32 === 1'b1) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);

    // start held through a divide, then back-to-back accept
    held_start(1'b0, 64'd1000, 64'd3, 6'd0, 6'd2, 64'h1234, 64'h10);
    drain();
    held_start(1'b1, 64'd200, 64'd7, 6'd0, 6'd2, 64'd20, 64'd20);
    drain();

    // randomized mix on both instances
    for (int i = 0; i < 160; i++) begin
      sel = $urandom_range(0, 3);
      rop = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd1 : 6'($urandom_range(0, 63));
      rfn = 6'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       rb = 64'd0;
        1:       rb = ra;
        default: rb = {$urandom, $urandom};
      endcase
      issue(i[0], rop, rfn, ra, rb);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    n_checks++;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
